// File: rtl/fft32_frame_feeder.sv
// Ping-pong frame buffer in front of FFT32: accepts a valid/ready sample stream and
// replays each complete frame as a START pulse followed by N gap-free samples on DR/DI.
module fft32_frame_feeder #(
   parameter int nb  = 16,
   parameter int N   = 32,
   parameter int GAP = 0
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          IN_VALID,
   output logic          IN_READY,
   input  logic [nb-1:0] IN_DR,
   input  logic [nb-1:0] IN_DI,
   input  logic          IN_LAST,
   output logic          START,
   output logic [nb-1:0] DR,
   output logic [nb-1:0] DI,
   output logic          BUSY,
   output logic          ERR
);

   localparam int            AW       = $clog2(N);
   localparam int            GW       = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_STREAM, S_GAP} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   widx_q, widx_d;
   logic [AW-1:0]   ridx_q, ridx_d;
   logic            wbank_q, wbank_d;
   logic            rbank_q, rbank_d;
   logic [1:0]      full_q, full_d;
   logic [1:0]      filled;
   logic [GW-1:0]   gap_q, gap_d;
   logic            err_q, err_d;
   logic            rdy_en_q;
   logic            hs, wr_last, rd_release;
   logic [AW:0]     rd_addr;
   logic [2*nb-1:0] mem [2*N];
   logic [2*nb-1:0] rd_data_q;

   // Ready is held low through reset and for the first edge after release.
   assign IN_READY = rdy_en_q & ~full_q[wbank_q];
   assign hs       = IN_VALID & IN_READY;
   assign wr_last  = hs & (widx_q == LAST_IDX);

   // Full flags as they will be after this edge's write-fill, used to chain START without an idle cycle.
   assign filled[0] = full_q[0] | (wr_last & ~wbank_q);
   assign filled[1] = full_q[1] | (wr_last &  wbank_q);

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      widx_d  = widx_q;
      wbank_d = wbank_q;
      err_d   = err_q;
      if (hs) begin
         widx_d = widx_q + AW'(1);
         if (IN_LAST != (widx_q == LAST_IDX)) err_d = 1'b1;
         if (widx_q == LAST_IDX) wbank_d = ~wbank_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      ridx_d     = ridx_q;
      rbank_d    = rbank_q;
      gap_d      = gap_q;
      rd_release = 1'b0;
      rd_addr    = {rbank_q, ridx_q};
      case (state_q)
         S_IDLE: begin
            if (filled[rbank_q]) state_d = S_START;
         end
         S_START: begin
            ridx_d  = '0;
            rd_addr = {rbank_q, {AW{1'b0}}};
            state_d = S_STREAM;
         end
         S_STREAM: begin
            ridx_d  = ridx_q + AW'(1);
            rd_addr = {rbank_q, ridx_q + AW'(1)};
            if (ridx_q == LAST_IDX) begin
               rd_release = 1'b1;
               rbank_d    = ~rbank_q;
               if (GAP > 0) begin
                  state_d = S_GAP;
                  gap_d   = '0;
               end else if (filled[~rbank_q]) begin
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (gap_q == GW'(GAP - 1)) state_d = filled[rbank_q] ? S_START : S_IDLE;
            else                       gap_d   = gap_q + GW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      full_d = full_q;
      if (rd_release) full_d[rbank_q] = 1'b0;
      if (wr_last)    full_d[wbank_q] = 1'b1;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= S_IDLE;
         widx_q   <= '0;
         ridx_q   <= '0;
         wbank_q  <= 1'b0;
         rbank_q  <= 1'b0;
         full_q   <= '0;
         gap_q    <= '0;
         err_q    <= 1'b0;
         rdy_en_q <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         state_q  <= state_d;
         widx_q   <= widx_d;
         ridx_q   <= ridx_d;
         wbank_q  <= wbank_d;
         rbank_q  <= rbank_d;
         full_q   <= full_d;
         gap_q    <= gap_d;
         err_q    <= err_d;
         rdy_en_q <= 1'b1;
      end
   end

   // NOTE: the sample RAM has no reset; the full flags alone decide what is valid.
   always_ff @(posedge CLK) begin
      if (hs) mem[{wbank_q, widx_q}] <= {IN_DR, IN_DI};
      rd_data_q <= mem[rd_addr];
   end

   assign START = (state_q == S_START);
   assign DR    = (state_q == S_STREAM) ? rd_data_q[2*nb-1:nb] : '0;
   assign DI    = (state_q == S_STREAM) ? rd_data_q[nb-1:0]    : '0;
   assign BUSY  = (state_q != S_IDLE) | (|full_q);
   assign ERR   = err_q;

endmodule

// File: tb/tb_fft32_frame_feeder.sv
// Directed bench for fft32_frame_feeder: one GAP=0 instance for framing, back-pressure
// and reset, one GAP=4 instance for inter-frame spacing.
module tb_fft32_frame_feeder;

   localparam int NB = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic [NB-1:0] in_dr = '0;
   logic [NB-1:0] in_di = '0;
   logic          in_ready, start_o, busy_o, err_o;
   logic [NB-1:0] dr_o, di_o;

   logic          g_valid = 1'b0;
   logic          g_last = 1'b0;
   logic [NB-1:0] g_dr = '0;
   logic [NB-1:0] g_di = '0;
   logic          g_ready, g_start, g_busy, g_err;
   logic [NB-1:0] g_dr_o, g_di_o;

   int checks = 0;
   int failures = 0;
   int start_cnt = 0;

   int            starts[$];
   logic [NB-1:0] got_dr[$];
   logic [NB-1:0] got_di[$];

   fft32_frame_feeder #(.nb(NB), .N(32), .GAP(0)) dut (
      .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
      .IN_DR(in_dr), .IN_DI(in_di), .IN_LAST(in_last), .START(start_o),
      .DR(dr_o), .DI(di_o), .BUSY(busy_o), .ERR(err_o)
   );

   fft32_frame_feeder #(.nb(NB), .N(32), .GAP(4)) dut_g (
      .CLK(clk), .RST(rst), .IN_VALID(g_valid), .IN_READY(g_ready),
      .IN_DR(g_dr), .IN_DI(g_di), .IN_LAST(g_last), .START(g_start),
      .DR(g_dr_o), .DI(g_di_o), .BUSY(g_busy), .ERR(g_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (start_o) start_cnt <= start_cnt + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Presents one sample and returns at the cycle after its handshake edge.
   task automatic send(input logic [NB-1:0] dr, input logic [NB-1:0] di, input logic last);
      int budget = 200;
      in_valid = 1'b1;
      in_dr    = dr;
      in_di    = di;
      in_last  = last;
      @(negedge clk);
      while (!in_ready && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) check("send_ready", 32'(in_ready), 32'd1);
      next_cycle();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      int idx, stalls, first_stall, cnt, s0;
      logic [NB-1:0] first_dr, last_dr;

      // Reset held: outputs quiet regardless of IN_VALID.
      for (int k = 0; k < 2; k++) begin
         next_cycle();
         in_valid = k[0];
         @(negedge clk);
         check("rst_start", 32'(start_o), 32'd0);
         check("rst_dr",    32'(dr_o),    32'd0);
         check("rst_di",    32'(di_o),    32'd0);
         check("rst_err",   32'(err_o),   32'd0);
         check("rst_busy",  32'(busy_o),  32'd0);
         check("rst_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      next_cycle();
      rst = 1'b1;
      #1;
      check("ready_before_edge", 32'(in_ready), 32'd0);
      next_cycle();
      check("ready_after_edge", 32'(in_ready), 32'd1);

      // Single frame: START one cycle after the last handshake, samples next.
      for (int i = 0; i < 32; i++)
         send(16'(32'h0100 + i), 16'(32'h0200 + i), i == 31);
      @(negedge clk);
      check("t2_start", 32'(start_o), 32'd1);
      check("t2_dr_at_start", 32'(dr_o), 32'd0);
      for (int i = 0; i < 32; i++) begin
         next_cycle();
         @(negedge clk);
         check("t2_dr", 32'(dr_o), 32'h0100 + i);
         check("t2_di", 32'(di_o), 32'h0200 + i);
      end
      next_cycle();
      @(negedge clk);
      check("t2_busy_after", 32'(busy_o), 32'd0);
      check("t2_dr_after", 32'(dr_o), 32'd0);
      check("t2_err", 32'(err_o), 32'd0);

      // Four frames with IN_VALID held high: back-pressure and 33-cycle START period.
      next_cycle();
      idx = 0;
      stalls = 0;
      first_stall = -1;
      for (int r = 0; r < 200; r++) begin
         in_valid = (idx < 128);
         in_dr    = 16'(32'h1000 + idx);
         in_di    = 16'(32'h2000 + idx);
         in_last  = (idx % 32 == 31);
         @(negedge clk);
         if (start_o) starts.push_back(r);
         if (dr_o != '0) begin
            got_dr.push_back(dr_o);
            got_di.push_back(di_o);
         end
         if (in_valid) begin
            if (in_ready) idx++;
            else begin
               if (first_stall < 0) first_stall = r;
               stalls++;
            end
         end
         next_cycle();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("t3_accepted", 32'(idx), 32'd128);
      check("t3_stalls", 32'(stalls), 32'd2);
      check("t3_first_stall", 32'(first_stall), 32'd64);
      check("t3_start_count", 32'(starts.size()), 32'd4);
      if (starts.size() > 0) check("t3_first_start", 32'(starts[0]), 32'd32);
      for (int k = 1; k < starts.size(); k++)
         check("t3_start_period", 32'(starts[k] - starts[k-1]), 32'd33);
      check("t3_sample_count", 32'(got_dr.size()), 32'd128);
      for (int i = 0; i < got_dr.size() && i < 128; i++) begin
         check("t3_dr", 32'(got_dr[i]), 32'h1000 + i);
         check("t3_di", 32'(got_di[i]), 32'h2000 + i);
      end
      check("t3_err", 32'(err_o), 32'd0);

      // GAP=4 instance: two queued frames, START 37 cycles apart, zeros in the gap.
      starts.delete();
      idx = 0;
      cnt = 0;
      for (int r = 0; r < 120; r++) begin
         g_valid = (idx < 64);
         g_dr    = 16'(32'h7000 + idx);
         g_di    = 16'(32'h7800 + idx);
         g_last  = (idx % 32 == 31);
         @(negedge clk);
         if (g_start) starts.push_back(r);
         if (g_dr_o != '0) cnt++;
         if (r == 64) check("t4_last_a", 32'(g_dr_o), 32'h701F);
         if (r >= 65 && r <= 68) begin
            check("t4_gap_dr", 32'(g_dr_o), 32'd0);
            check("t4_gap_di", 32'(g_di_o), 32'd0);
         end
         if (r == 66) check("t4_gap_busy", 32'(g_busy), 32'd1);
         if (r == 70) check("t4_first_b", 32'(g_dr_o), 32'h7020);
         if (g_valid && g_ready) idx++;
         next_cycle();
      end
      g_valid = 1'b0;
      g_last  = 1'b0;
      check("t4_sample_count", 32'(cnt), 32'd64);
      check("t4_start_count", 32'(starts.size()), 32'd2);
      if (starts.size() == 2) begin
         check("t4_first_start", 32'(starts[0]), 32'd32);
         check("t4_start_period", 32'(starts[1] - starts[0]), 32'd37);
      end

      // Early IN_LAST: sticky ERR, frame still emitted whole.
      for (int i = 0; i < 5; i++)
         send(16'(32'h3000 + i), 16'(32'h4000 + i), 1'b0);
      check("t5_err_before", 32'(err_o), 32'd0);
      send(16'h3005, 16'h4005, 1'b1);
      check("t5_err_set", 32'(err_o), 32'd1);
      for (int i = 6; i < 32; i++)
         send(16'(32'h3000 + i), 16'(32'h4000 + i), i == 31);
      check("t5_start", 32'(start_o), 32'd1);
      cnt = 0;
      first_dr = '0;
      last_dr  = '0;
      for (int i = 0; i < 34; i++) begin
         next_cycle();
         @(negedge clk);
         if (dr_o != '0) begin
            if (cnt == 0) first_dr = dr_o;
            last_dr = dr_o;
            cnt++;
         end
      end
      check("t5_sample_count", 32'(cnt), 32'd32);
      check("t5_first", 32'(first_dr), 32'h3000);
      check("t5_last", 32'(last_dr), 32'h301F);
      check("t5_err_sticky", 32'(err_o), 32'd1);
      next_cycle();

      // Reset mid-stream with a partial second frame in flight.
      for (int i = 0; i < 32; i++)
         send(16'(32'h5000 + i), 16'(32'h5800 + i), i == 31);
      check("t6_start", 32'(start_o), 32'd1);
      for (int i = 0; i < 10; i++)
         send(16'(32'h6000 + i), 16'(32'h6800 + i), 1'b0);
      @(negedge clk);
      check("t6_dr9", 32'(dr_o), 32'h5009);
      next_cycle();
      @(negedge clk);
      check("t6_dr10", 32'(dr_o), 32'h500A);
      check("t6_di10", 32'(di_o), 32'h580A);
      #1;
      rst = 1'b0;
      #1;
      check("t6_rst_dr", 32'(dr_o), 32'd0);
      check("t6_rst_di", 32'(di_o), 32'd0);
      check("t6_rst_start", 32'(start_o), 32'd0);
      check("t6_rst_busy", 32'(busy_o), 32'd0);
      check("t6_rst_err", 32'(err_o), 32'd0);
      check("t6_rst_ready", 32'(in_ready), 32'd0);
      next_cycle();
      next_cycle();
      rst = 1'b1;
      s0 = start_cnt;
      for (int i = 0; i < 31; i++)
         send(16'(32'h6100 + i), 16'(32'h6900 + i), 1'b0);
      for (int i = 0; i < 40; i++) next_cycle();
      check("t6_no_start", 32'(start_cnt - s0), 32'd0);
      send(16'h611F, 16'h691F, 1'b1);
      check("t6_start_after", 32'(start_o), 32'd1);
      next_cycle();
      @(negedge clk);
      check("t6_first_after", 32'(dr_o), 32'h6100);
      for (int i = 0; i < 34; i++) next_cycle();
      check("t6_err", 32'(err_o), 32'd0);
      check("t6_busy_end", 32'(busy_o), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
